// File: rtl/mem_adapter_pkg.sv
// Shared types for the vector-core to storage_controller request adapter.
package mem_adapter_pkg;

  localparam int unsigned MemDataW = 32;
  localparam int unsigned MemBeW   = MemDataW / 8;

  localparam logic [31:0] SramLimitDefault = 32'h0000_1000;

  typedef struct packed {
    logic [31:0]          addr;
    logic                 we;
    logic [MemBeW-1:0]    be;
    logic [MemDataW-1:0]  wdata;
    logic                 ext;
    logic                 err;
  } mem_req_t;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StErr
  } issuer_state_e;

  function automatic logic is_external(input logic [31:0] addr, input logic [31:0] limit);
    return addr >= limit;
  endfunction

endpackage

// File: rtl/mem_req_fifo.sv
// In-order request buffer; pointers carry one extra wrap bit so full and empty differ in the MSB.
module mem_req_fifo
  import mem_adapter_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push_i,
  input  mem_req_t wdata_i,
  input  logic     pop_i,
  output mem_req_t rdata_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned PtrW  = AddrW + 1;

  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic            do_push, do_pop;
  mem_req_t        mem_q [Depth];

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AddrW] != rptr_q[AddrW]) &&
                   (wptr_q[AddrW-1:0] == rptr_q[AddrW-1:0]);

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + {{AddrW{1'b0}}, 1'b1};
    if (do_pop)  rptr_d = rptr_q + {{AddrW{1'b0}}, 1'b1};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage needs no reset: contents are only visible through the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AddrW-1:0]] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q[AddrW-1:0]];

endmodule

// File: rtl/mem_req_adapter.sv
// Bridges the core req/gnt port to the single-outstanding storage_controller port.
// MEM_ADAPTER_ERR_EN enables request error classification and error responses.
module mem_req_adapter
  import mem_adapter_pkg::*;
#(
  parameter int unsigned MEM_W      = MemDataW,
  parameter int unsigned MEM_SZ     = 262144,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] SRAM_LIMIT = SramLimitDefault
) (
  input  logic               clk,
  input  logic               rst,
  // core side
  input  logic               mem_req_i,
  output logic               mem_gnt_o,
  input  logic [31:0]        mem_addr_i,
  input  logic               mem_we_i,
  input  logic [MEM_W/8-1:0] mem_be_i,
  input  logic [MEM_W-1:0]   mem_wdata_i,
  output logic               mem_rvalid_o,
  output logic [MEM_W-1:0]   mem_rdata_o,
  output logic               mem_err_o,
  input  logic               prog_mode_i,
  // storage_controller side
  output logic               memory_access_o,
  output logic               memory_is_writing_o,
  output logic               external_storage_access_o,
  output logic [31:0]        addr_o,
  output logic [MEM_W-1:0]   d_in_o,
  output logic [MEM_W/8-1:0] mem_be_o,
  input  logic [MEM_W-1:0]   d_out_i,
  input  logic               out_valid_i,
  output logic               busy_o
);

`ifdef MEM_ADAPTER_ERR_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  // 33 bits so SRAM_LIMIT + MEM_SZ cannot wrap.
  localparam logic [32:0] ExtEnd = 33'(SRAM_LIMIT) + 33'(MEM_SZ);

  logic     fifo_full, fifo_empty;
  logic     push, pop;
  mem_req_t push_req, head_req;

  issuer_state_e state_q, state_d;

  logic               access_q, access_d;
  logic               wr_q, wr_d;
  logic               ext_q, ext_d;
  logic [31:0]        addr_q, addr_d;
  logic [MEM_W-1:0]   din_q, din_d;
  logic [MEM_W/8-1:0] be_q, be_d;
  logic               req_we_q, req_we_d;
  logic               rvalid_q, rvalid_d;
  logic [MEM_W-1:0]   rdata_q, rdata_d;
  logic               err_q, err_d;

  // ---------------------------------------------------------------------------
  // Grant and classification
  // ---------------------------------------------------------------------------
  assign mem_gnt_o = mem_req_i & ~fifo_full & ~prog_mode_i;
  assign push      = mem_gnt_o;

  always_comb begin
    push_req       = '0;
    push_req.addr  = mem_addr_i;
    push_req.we    = mem_we_i;
    push_req.be    = mem_be_i;
    push_req.wdata = mem_wdata_i;
    push_req.ext   = is_external(mem_addr_i, SRAM_LIMIT);
    push_req.err   = ErrEn & ((push_req.ext & mem_we_i) |
                              (push_req.ext & ({1'b0, mem_addr_i} >= ExtEnd)) |
                              (mem_addr_i[1:0] != 2'b00));
  end

  mem_req_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (push_req),
    .pop_i   (pop),
    .rdata_o (head_req),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign pop = (state_q == StIdle) & ~fifo_empty & ~prog_mode_i;

  // ---------------------------------------------------------------------------
  // Issuer FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (pop) state_d = head_req.err ? StErr : StAccess;
      end
      StAccess: begin
        if (out_valid_i || prog_mode_i) state_d = StIdle;
      end
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    access_d = access_q;
    wr_d     = wr_q;
    ext_d    = ext_q;
    addr_d   = addr_q;
    din_d    = din_q;
    be_d     = be_q;
    req_we_d = req_we_q;
    rvalid_d = 1'b0;
    rdata_d  = rdata_q;
    err_d    = err_q;
    unique case (state_q)
      StIdle: begin
        if (pop && !head_req.err) begin
          access_d = 1'b1;
          // External storage cannot be written; such writes run as reads.
          wr_d     = head_req.we & ~head_req.ext;
          ext_d    = head_req.ext;
          addr_d   = head_req.addr;
          din_d    = head_req.wdata;
          be_d     = head_req.be;
          req_we_d = head_req.we;
        end
      end
      StAccess: begin
        if (out_valid_i || prog_mode_i) begin
          access_d = 1'b0;
          wr_d     = 1'b0;
          ext_d    = 1'b0;
          rvalid_d = 1'b1;
          if (out_valid_i) begin
            rdata_d = req_we_q ? '0 : d_out_i;
            err_d   = 1'b0;
          end else begin
            rdata_d = '0;
            err_d   = ErrEn;
          end
        end
      end
      StErr: begin
        rvalid_d = 1'b1;
        rdata_d  = '0;
        err_d    = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      access_q <= 1'b0;
      wr_q     <= 1'b0;
      ext_q    <= 1'b0;
      addr_q   <= '0;
      din_q    <= '0;
      be_q     <= '0;
      req_we_q <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      access_q <= access_d;
      wr_q     <= wr_d;
      ext_q    <= ext_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      be_q     <= be_d;
      req_we_q <= req_we_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign memory_access_o           = access_q;
  assign memory_is_writing_o       = wr_q;
  assign external_storage_access_o = ext_q;
  assign addr_o                    = addr_q;
  assign d_in_o                    = din_q;
  assign mem_be_o                  = be_q;

  assign mem_rvalid_o = rvalid_q;
  assign mem_rdata_o  = rdata_q;
  assign mem_err_o    = err_q & ErrEn;

  assign busy_o = ~fifo_empty | (state_q != StIdle);

endmodule
